// File: rtl/intc_pkg.sv
// ---------------------------------------------------------------------------
// intc_pkg
// Shared constants, bus FSM state type and a priority helper for the
// interrupt controller.
//
// Contents:
//   NUM_SRC                      number of interrupt sources (4)
//   PEND_OFS / MASK_OFS / CAUSE_OFS  register byte offsets
//   MASK_RST                     mask value after reset (keyboard + timer)
//   SRC_KBD / SRC_TMR            source index constants
//   busState_t                   bus FSM states (IDLE, DONE)
//   lowestOneHot()               isolates the lowest set bit of a vector
//
// Build option: INTC_EDGE_EN (used by intc_sync_edge) selects rising-edge
// capture instead of level capture.
// ---------------------------------------------------------------------------
package intc_pkg;

    localparam int NUM_SRC = 4;

    localparam logic [3:0] PEND_OFS  = 4'h0;
    localparam logic [3:0] MASK_OFS  = 4'h4;
    localparam logic [3:0] CAUSE_OFS = 4'h8;

    localparam logic [NUM_SRC-1:0] MASK_RST = 4'b0011;

    localparam int SRC_KBD = 0;
    localparam int SRC_TMR = 1;

    typedef enum logic {
        IDLE = 1'b0,
        DONE = 1'b1
    } busState_t;

    // Returns a one-hot vector of the lowest-index set bit of v (bit0 has
    // the highest priority); all zeros when v is zero.
    function automatic logic [NUM_SRC-1:0] lowestOneHot(input logic [NUM_SRC-1:0] v);
        logic [NUM_SRC-1:0] result;
        result = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                result    = '0;
                result[i] = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/intc_sync_edge.sv
// ---------------------------------------------------------------------------
// intc_sync_edge
// Brings one raw interrupt request into the clk domain through a 2-flop
// synchronizer and produces the capture condition for its PENDING bit.
//
// Build option INTC_EDGE_EN:
//   defined   : capture = rising edge of the synchronized request (one extra
//               flop remembers the previous synchronized value)
//   undefined : capture = synchronized level
//
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset
//   asyncIn   in   raw request, may be asynchronous to clk
//   capture   out  set condition for the PENDING bit of this source
// ---------------------------------------------------------------------------
module intc_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic asyncIn,
    output logic capture
);

    // syncReg[0] is the metastability-catching stage, syncReg[1] the
    // stable synchronized copy that the rest of the design may use.
    logic [1:0] syncReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            syncReg <= 2'b00;
        end else begin
            syncReg <= {syncReg[0], asyncIn};
        end
    end

`ifdef INTC_EDGE_EN
    logic edgeReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            edgeReg <= 1'b0;
        end else begin
            edgeReg <= syncReg[1];
        end
    end

    // The third edge that samples the input high is the one where the
    // synchronized value is 1 and the previous synchronized value is 0.
    assign capture = syncReg[1] & ~edgeReg;
`else
    assign capture = syncReg[1];
`endif

endmodule

// File: rtl/interrupt_controller.sv
// ---------------------------------------------------------------------------
// interrupt_controller
// Four-source interrupt controller with a PENDING/MASK register pair, fixed
// priority cause encoding (bit0 highest) and a small memory-mapped bus slave.
//
// Build option INTC_EDGE_EN: rising-edge capture of requests (default is
// level capture, see intc_sync_edge).
//
// Register map (byte offsets on IntcAddr):
//   0x0 PENDING  read; write-1-to-clear bits[3:0]
//   0x4 MASK     read/write bits[3:0]
//   0x8 CAUSE    read-only, returns OutCause
//   other        read 0, writes ignored
//
// Ports:
//   clk          in   CPU clock
//   rst          in   synchronous active-high reset
//   SrcReq       in   raw requests (bit0 keyboard, bit1 timer, 2-3 spare)
//   InteAccept   in   CPU acknowledge of the presented interrupt
//   OutINTE      out  interrupt request to the CPU
//   OutCause     out  one-hot cause of the presented interrupt
//   SrcAck       out  per-source acknowledge pulse
//   ChipSelect   in   bus select
//   IntcAddr     in   bus byte offset
//   MemRead      in   bus read strobe
//   MemWrite     in   bus write strobe
//   WriteData    in   bus write data
//   MemReadData  out  registered bus read data
//   MemOK        out  one-cycle bus completion pulse
// ---------------------------------------------------------------------------
module interrupt_controller
    import intc_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_SRC-1:0]  SrcReq,
    input  logic                InteAccept,
    output logic                OutINTE,
    output logic [31:0]         OutCause,
    output logic [NUM_SRC-1:0]  SrcAck,
    input  logic                ChipSelect,
    input  logic [3:0]          IntcAddr,
    input  logic                MemRead,
    input  logic                MemWrite,
    input  logic [31:0]         WriteData,
    output logic [31:0]         MemReadData,
    output logic                MemOK
);

    // ------------------------------------------------------------------
    // Source synchronization / capture
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0] captureVec;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : gSrc
            intc_sync_edge uSyncEdge (
                .clk     (clk),
                .rst     (rst),
                .asyncIn (SrcReq[gi]),
                .capture (captureVec[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0] pendingReg, pendingNext;
    logic [NUM_SRC-1:0] maskReg, maskNext;
    logic [31:0]        readDataReg, readDataNext;
    busState_t          stateReg, stateNext;

    // ------------------------------------------------------------------
    // Interrupt presentation
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0] activeVec;
    logic [NUM_SRC-1:0] presentedVec;
    logic               acceptFire;

    assign activeVec    = pendingReg & maskReg;
    assign presentedVec = lowestOneHot(activeVec);
    assign OutINTE      = |activeVec;
    assign OutCause     = {{(32 - NUM_SRC){1'b0}}, presentedVec};

    // An accept only means something while a request is being presented.
    assign acceptFire   = InteAccept & OutINTE;
    assign SrcAck       = presentedVec & {NUM_SRC{acceptFire}};

    // ------------------------------------------------------------------
    // Bus decode. A simultaneous read and write is handled as a read only.
    // ------------------------------------------------------------------
    logic busAccess;
    logic doRead;
    logic doWrite;

    assign busAccess = (stateReg == IDLE) & ChipSelect & (MemRead | MemWrite);
    assign doRead    = busAccess & MemRead;
    assign doWrite   = busAccess & MemWrite & ~MemRead;

    // Upper write-data bits carry no register content.
    logic unusedWriteBits;
    assign unusedWriteBits = ^WriteData[31:NUM_SRC];

    // ------------------------------------------------------------------
    // PENDING next state, per bit: set has priority over any clear.
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0] w1cVec;
    logic [NUM_SRC-1:0] acceptClrVec;

    assign w1cVec       = (doWrite && (IntcAddr == PEND_OFS)) ? WriteData[NUM_SRC-1:0]
                                                              : '0;
    assign acceptClrVec = SrcAck;

    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : gPend
            assign pendingNext[gi] = captureVec[gi] |
                                     (pendingReg[gi] & ~(w1cVec[gi] | acceptClrVec[gi]));
        end
    endgenerate

    // ------------------------------------------------------------------
    // MASK and read-data next state
    // ------------------------------------------------------------------
    always_comb begin
        maskNext     = maskReg;
        readDataNext = readDataReg;

        if (doWrite && (IntcAddr == MASK_OFS)) begin
            maskNext = WriteData[NUM_SRC-1:0];
        end

        // Read data reflects register contents before this edge's updates.
        if (doRead) begin
            case (IntcAddr)
                PEND_OFS:  readDataNext = {{(32 - NUM_SRC){1'b0}}, pendingReg};
                MASK_OFS:  readDataNext = {{(32 - NUM_SRC){1'b0}}, maskReg};
                CAUSE_OFS: readDataNext = OutCause;
                default:   readDataNext = 32'h0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bus FSM: IDLE accepts an access, DONE signals completion for one
    // cycle and ignores any strobes present meanwhile.
    // ------------------------------------------------------------------
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (busAccess) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign MemOK       = (stateReg == DONE);
    assign MemReadData = readDataReg;

    // ------------------------------------------------------------------
    // State registers; reset overrides any concurrent access or accept.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pendingReg  <= '0;
            maskReg     <= MASK_RST;
            readDataReg <= 32'h0;
            stateReg    <= IDLE;
        end else begin
            pendingReg  <= pendingNext;
            maskReg     <= maskNext;
            readDataReg <= readDataNext;
            stateReg    <= stateNext;
        end
    end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: `clk` and `rst`.
REQ-002 SHALL have ports (name, direction, width, meaning):
- `clk`, in, 1, CPU clock.
- `rst`, in, 1, synchronous active-high reset.
- `SrcReq`, in, 4, raw interrupt requests; bit0 keyboard, bit1 timer, bits2-3 spare; may be asynchronous to `clk`.
- `InteAccept`, in, 1, CPU acknowledge of the presented interrupt.
- `OutINTE`, out, 1, interrupt request to the CPU.
- `OutCause`, out, 32, one-hot cause code.
- `SrcAck`, out, 4, per-source acknowledge pulse.
- `ChipSelect`, in, 1, bus select.
- `IntcAddr`, in, 4, byte offset.
- `MemRead`, in, 1, bus read strobe.
- `MemWrite`, in, 1, bus write strobe.
- `WriteData`, in, 32, bus write data.
- `MemReadData`, out, 32, bus read data.
- `MemOK`, out, 1, bus completion pulse.

Function
REQ-003 SHALL pass each `SrcReq` bit through a 2-flop synchronizer before any other logic uses it.
REQ-004 SHALL hold a 4-bit PENDING register and a 4-bit MASK register.
REQ-005 SHALL set PENDING[i] on the capture condition of source i (see Configuration). When the input is held high, PENDING[i] SHALL be set by the 3rd rising edge of `clk` that samples `SrcReq[i]` high.
REQ-006 SHALL drive `OutINTE` = |(PENDING & MASK), combinationally from registers.
REQ-007 SHALL drive `OutCause` = 32'h1 << i, where i is the lowest-index set bit of PENDING & MASK (fixed priority, bit0 highest). `OutCause` SHALL be 0 when `OutINTE` = 0.
REQ-008 SHALL drive `SrcAck[i]` = `InteAccept` & `OutINTE` & (presented index == i), combinationally, for one cycle.
REQ-009 When `InteAccept` & `OutINTE` is high at a clock edge, the controller SHALL clear PENDING of the presented source at that edge.
REQ-010 SHALL ignore `InteAccept` when `OutINTE` = 0.
REQ-011 When a set condition and a clear (accept or W1C) for the same bit occur in the same cycle, set SHALL win.
REQ-012 SHALL implement this register map at `IntcAddr` offsets:
- 0x0 PENDING: read; write-1-to-clear using bits[3:0].
- 0x4 MASK: read/write bits[3:0].
- 0x8 CAUSE: read-only, returns `OutCause`.
- Other offsets: read 0, writes ignored.
- Unused data bits read as 0.
REQ-013 SHALL use a bus FSM with states IDLE, DONE:
- IDLE → DONE when `ChipSelect` & (`MemRead` | `MemWrite`); the write is performed and `MemReadData` is registered at that edge.
- DONE: `MemOK` = 1 for exactly one cycle, then → IDLE unconditionally.
- Strobes arriving in DONE SHALL be ignored.
REQ-014 SHALL give read-side priority to a write when `MemRead` and `MemWrite` are both high.
REQ-015 Masking a pending source SHALL NOT clear PENDING; unmasking it SHALL re-assert `OutINTE` on the next cycle.

Reset
REQ-016 On `rst` at a clock edge, the controller SHALL set:
- PENDING = 0, MASK = 4'b0011, synchronizer and edge flops = 0.
- Bus FSM = IDLE, `MemOK` = 0, `MemReadData` = 0.
REQ-017 `rst` SHALL override any concurrent bus access or accept; an access interrupted mid-operation SHALL be dropped, with no `MemOK`.

Configuration
REQ-018 With `INTC_EDGE_EN` defined, the capture condition SHALL be a rising edge of the synchronized input: set once per 0→1 transition, and a held-high level SHALL NOT re-set after clear.
REQ-019 Without `INTC_EDGE_EN`, the capture condition SHALL be level: PENDING[i] is set every cycle the synchronized input is high, so accept or W1C only sticks once the source deasserts.

Structure
REQ-020 Package `intc_pkg` SHALL hold:
- NUM_SRC = 4.
- Offsets PEND_OFS = 0x0, MASK_OFS = 0x4, CAUSE_OFS = 0x8.
- MASK_RST = 4'b0011.
- Source index constants SRC_KBD = 0, SRC_TMR = 1.
- Bus FSM state typedef.
REQ-021 Sub-module `intc_sync_edge` (2-flop sync, plus an edge flop under `INTC_EDGE_EN`) SHALL be instantiated once per source.

Verification
REQ-022 Bench SHALL cover these scenarios (stimulus -> required response):
- Reset, then `SrcReq` = 4'b0010 held -> `OutINTE` = 1 and `OutCause` = 32'h2 after the 3rd edge; read 0x0 -> 32'h2 with `MemOK` one cycle after the strobe.
- Sources 0 and 1 pending -> `OutCause` = 32'h1; pulse `InteAccept` -> `SrcAck` = 4'b0001, then `OutCause` = 32'h2 next cycle.
- Write 0x4 = 32'h0 with source 0 pending -> `OutINTE` = 0; write 0x4 = 32'h1 -> `OutINTE` = 1, `OutCause` = 32'h1.
- `INTC_EDGE_EN` defined, source 0 new rising edge in the same cycle as W1C 0x0 = 32'h1 -> PENDING[0] stays 1.
- `InteAccept` with `OutINTE` = 0 -> PENDING unchanged, `SrcAck` = 0; read 0xC -> 0.
- `rst` asserted during DONE -> `MemOK` = 0 next cycle, PENDING = 0, MASK reads 32'h3.
